// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between a multi-cycle MIPS-style datapath (master) and its
// sequencing controller (slave).
interface multi_cycle_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  state;
    logic        pc_we;
    logic        ir_we;
    logic [1:0]  npc_sel;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        alu_src;
    logic        ext_op;
    logic [2:0]  alu_op;
    logic        mem_re;
    logic        mem_we;
    logic        illegal;
    logic [31:0] instr_cnt;

    // Handshake: mem_re/mem_we are requests held high every cycle until the
    // memory answers with mem_ready=1 in the same cycle; the access completes
    // on that clock edge and the request drops the following cycle.
    modport master (
        output op, func, zero, mem_ready,
        input  state, pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel,
               alu_src, ext_op, alu_op, mem_re, mem_we, illegal, instr_cnt
    );

    modport slave (
        input  op, func, zero, mem_ready,
        output state, pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel,
               alu_src, ext_op, alu_op, mem_re, mem_we, illegal, instr_cnt
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller: IF/ID/EX/MEM/WB sequencer with a latched
// instruction class and a retired-instruction counter.
module multi_cycle_ctrl (
    input  logic              clk,
    input  logic              reset,
    multi_cycle_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JR, C_ILL
    } class_t;

    state_t      state_q, state_d;
    class_t      cls_q, dec_cls;
    logic [31:0] cnt_q;
    logic        retire;

    logic        pc_we_c, ir_we_c, reg_we_c, mem_re_c, mem_we_c, illegal_c;
    logic [1:0]  npc_sel_c, reg_dst_c, wd_sel_c;
    logic        alu_src_c, ext_op_c;
    logic [2:0]  alu_op_c;

    always_comb begin
        dec_cls = C_ILL;
        case (bus.op)
            6'h00: begin
                case (bus.func)
                    6'h00:   dec_cls = C_NOP;
                    6'h21:   dec_cls = C_ADDU;
                    6'h23:   dec_cls = C_SUBU;
                    6'h08:   dec_cls = C_JR;
                    default: dec_cls = C_ILL;
                endcase
            end
            6'h0D:   dec_cls = C_ORI;
            6'h0F:   dec_cls = C_LUI;
            6'h23:   dec_cls = C_LW;
            6'h2B:   dec_cls = C_SW;
            6'h04:   dec_cls = C_BEQ;
            6'h03:   dec_cls = C_JAL;
            default: dec_cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
            cls_q   <= C_NOP;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) cls_q <= dec_cls;
            if (retire) cnt_q <= cnt_q + 32'd1;
        end
    end

    // ALU setup stays stable across EX and MEM so the address holds during waits.
    always_comb begin
        alu_src_c = 1'b0;
        ext_op_c  = 1'b0;
        alu_op_c  = 3'b000;
        if (state_q == S_EX || state_q == S_MEM) begin
            case (cls_q)
                C_SUBU, C_BEQ: alu_op_c = 3'b001;
                C_ORI:   begin alu_op_c = 3'b010; alu_src_c = 1'b1; end
                C_LUI:   begin alu_op_c = 3'b011; alu_src_c = 1'b1; end
                C_LW, C_SW: begin alu_src_c = 1'b1; ext_op_c = 1'b1; end
                default: alu_op_c = 3'b000;
            endcase
        end
    end

    always_comb begin
        state_d   = S_IF;
        retire    = 1'b0;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        reg_we_c  = 1'b0;
        mem_re_c  = 1'b0;
        mem_we_c  = 1'b0;
        illegal_c = 1'b0;
        npc_sel_c = 2'b00;
        reg_dst_c = 2'b00;
        wd_sel_c  = 2'b00;
        case (state_q)
            S_IF: begin
                ir_we_c = 1'b1;
                pc_we_c = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (dec_cls)
                    C_NOP:   begin state_d = S_IF; retire = 1'b1; end
                    C_ILL:   begin state_d = S_IF; illegal_c = 1'b1; end
                    C_JAL:   state_d = S_WB;
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (cls_q)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ: begin
                        pc_we_c   = bus.zero;
                        npc_sel_c = 2'b01;
                        retire    = 1'b1;
                    end
                    C_JR: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = 2'b11;
                        retire    = 1'b1;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_re_c = (cls_q == C_LW);
                mem_we_c = (cls_q == C_SW);
                if (!bus.mem_ready) state_d = S_MEM;
                else if (cls_q == C_LW) state_d = S_WB;
                else retire = 1'b1;
            end
            S_WB: begin
                reg_we_c = 1'b1;
                retire   = 1'b1;
                case (cls_q)
                    C_ADDU, C_SUBU: reg_dst_c = 2'b01;
                    C_LW:           wd_sel_c  = 2'b01;
                    C_JAL: begin
                        pc_we_c   = 1'b1;
                        npc_sel_c = 2'b10;
                        reg_dst_c = 2'b10;
                        wd_sel_c  = 2'b10;
                    end
                    default: reg_dst_c = 2'b00;
                endcase
            end
            default: state_d = S_IF;
        endcase
    end

    assign bus.state     = state_q;
    assign bus.instr_cnt = cnt_q;
    assign bus.pc_we     = reset ? 1'b0 : pc_we_c;
    assign bus.ir_we     = reset ? 1'b0 : ir_we_c;
    assign bus.reg_we    = reset ? 1'b0 : reg_we_c;
    assign bus.mem_re    = reset ? 1'b0 : mem_re_c;
    assign bus.mem_we    = reset ? 1'b0 : mem_we_c;
    assign bus.illegal   = reset ? 1'b0 : illegal_c;
    assign bus.npc_sel   = reset ? 2'b00 : npc_sel_c;
    assign bus.reg_dst   = reset ? 2'b00 : reg_dst_c;
    assign bus.wd_sel    = reset ? 2'b00 : wd_sel_c;
    assign bus.alu_src   = reset ? 1'b0 : alu_src_c;
    assign bus.ext_op    = reset ? 1'b0 : ext_op_c;
    assign bus.alu_op    = reset ? 3'b000 : alu_op_c;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle expected outputs are queued
// by the driver and compared by a negedge monitor under a field mask.
module tb_multi_cycle_ctrl;
    typedef struct packed {
        logic [2:0]  state;
        logic        pc_we;
        logic        ir_we;
        logic [1:0]  npc_sel;
        logic        reg_we;
        logic [1:0]  reg_dst;
        logic [1:0]  wd_sel;
        logic        alu_src;
        logic        ext_op;
        logic [2:0]  alu_op;
        logic        mem_re;
        logic        mem_we;
        logic        illegal;
        logic [31:0] instr_cnt;
    } obs_t;

    localparam int W = $bits(obs_t);

    logic clk = 1'b0;
    logic reset = 1'b1;
    multi_cycle_ctrl_if bus();

    multi_cycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    obs_t        e, m;
    logic [31:0] cnt_model = 32'd0;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        obs_t got;
        logic [W-1:0] ev, mv;
        string nm;
        got = '{bus.state, bus.pc_we, bus.ir_we, bus.npc_sel, bus.reg_we,
                bus.reg_dst, bus.wd_sel, bus.alu_src, bus.ext_op, bus.alu_op,
                bus.mem_re, bus.mem_we, bus.illegal, bus.instr_cnt};
        if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            mv = mask_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if (((got ^ ev) & mv) !== '0) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (mask %h)", nm, got, ev, mv);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic exp_base(input logic [2:0] st);
        e = '0;
        m = '0;
        e.state = st;
        e.instr_cnt = cnt_model;
        m.state = '1;
        m.pc_we = 1'b1;
        m.ir_we = 1'b1;
        m.reg_we = 1'b1;
        m.mem_re = 1'b1;
        m.mem_we = 1'b1;
        m.illegal = 1'b1;
        m.instr_cnt = '1;
    endtask

    task automatic tick(input string nm);
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [2:0] aop, input logic src, input logic ext, input logic chk_ext);
        e.alu_op = aop; m.alu_op = '1;
        e.alu_src = src; m.alu_src = 1'b1;
        e.ext_op = ext; m.ext_op = chk_ext;
    endtask

    task automatic do_if(input logic [5:0] o, input logic [5:0] f, input string nm);
        bus.op = o;
        bus.func = f;
        exp_base(3'd0);
        e.ir_we = 1'b1; e.pc_we = 1'b1; m.npc_sel = '1;
        tick({nm, "_if"});
        exp_base(3'd1);
    endtask

    task automatic run_alu_rw(input logic [5:0] o, input logic [5:0] f, input logic [2:0] aop,
                              input logic src, input logic [1:0] rd, input string nm);
        do_if(o, f, nm);
        tick({nm, "_id"});
        exp_base(3'd2);
        set_alu(aop, src, 1'b0, (o == 6'h0D));
        tick({nm, "_ex"});
        exp_base(3'd4);
        e.reg_we = 1'b1;
        e.reg_dst = rd; m.reg_dst = '1;
        m.wd_sel = '1;
        tick({nm, "_wb"});
        cnt_model++;
    endtask

    task automatic run_mem(input logic is_lw, input int waits, input string nm);
        do_if(is_lw ? 6'h23 : 6'h2B, 6'h00, nm);
        tick({nm, "_id"});
        exp_base(3'd2);
        set_alu(3'b000, 1'b1, 1'b1, 1'b1);
        tick({nm, "_ex"});
        for (int i = 0; i <= waits; i++) begin
            bus.mem_ready = (i == waits);
            exp_base(3'd3);
            set_alu(3'b000, 1'b1, 1'b1, 1'b1);
            e.mem_re = is_lw; e.mem_we = !is_lw;
            tick({nm, "_mem"});
        end
        bus.mem_ready = 1'b0;
        if (is_lw) begin
            exp_base(3'd4);
            e.reg_we = 1'b1;
            e.wd_sel = 2'b01; m.wd_sel = '1;
            tick({nm, "_wb"});
        end
        cnt_model++;
    endtask

    task automatic run_beq(input logic z, input string nm);
        do_if(6'h04, 6'h00, nm);
        tick({nm, "_id"});
        bus.zero = z;
        exp_base(3'd2);
        set_alu(3'b001, 1'b0, 1'b0, 1'b0);
        e.pc_we = z;
        if (z) begin e.npc_sel = 2'b01; m.npc_sel = '1; end
        tick({nm, "_ex"});
        bus.zero = 1'b0;
        cnt_model++;
    endtask

    task automatic run_jr();
        do_if(6'h00, 6'h08, "jr");
        tick("jr_id");
        exp_base(3'd2);
        e.pc_we = 1'b1; e.npc_sel = 2'b11; m.npc_sel = '1;
        tick("jr_ex");
        cnt_model++;
    endtask

    task automatic run_jal();
        do_if(6'h03, 6'h00, "jal");
        tick("jal_id");
        exp_base(3'd4);
        e.pc_we = 1'b1; e.npc_sel = 2'b10; m.npc_sel = '1;
        e.reg_we = 1'b1;
        e.reg_dst = 2'b10; m.reg_dst = '1;
        e.wd_sel = 2'b10; m.wd_sel = '1;
        tick("jal_wb");
        cnt_model++;
    endtask

    task automatic run_nop(input string nm);
        do_if(6'h00, 6'h00, nm);
        tick({nm, "_id"});
        cnt_model++;
    endtask

    task automatic run_illegal(input logic [5:0] o, input logic [5:0] f, input string nm);
        do_if(o, f, nm);
        e.illegal = 1'b1;
        tick({nm, "_id"});
    endtask

    task automatic preload_cnt();
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        cnt_model = 32'hFFFF_FFFF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.op = 6'h00;
        bus.func = 6'h00;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_base(3'd0);
        m = '1;
        tick("reset_hold");
        reset = 1'b0;

        run_alu_rw(6'h00, 6'h21, 3'b000, 1'b0, 2'b01, "addu");
        run_alu_rw(6'h00, 6'h23, 3'b001, 1'b0, 2'b01, "subu");
        run_alu_rw(6'h0D, 6'h00, 3'b010, 1'b1, 2'b00, "ori");
        run_alu_rw(6'h0F, 6'h00, 3'b011, 1'b1, 2'b00, "lui");
        run_mem(1'b1, 3, "lw_w3");
        run_mem(1'b0, 0, "sw_w0");
        run_beq(1'b0, "beq_nt");
        run_beq(1'b1, "beq_t");
        run_jr();
        run_jal();
        run_nop("nop");
        run_illegal(6'h3F, 6'h00, "ill_op");
        run_illegal(6'h00, 6'h3F, "ill_func");
        run_mem(1'b1, 0, "lw_w0");
        run_mem(1'b0, 2, "sw_w2");

        // Reset mid sw wait with the counter about to wrap.
        preload_cnt();
        do_if(6'h2B, 6'h00, "sw_rst");
        tick("sw_rst_id");
        exp_base(3'd2);
        tick("sw_rst_ex");
        exp_base(3'd3);
        e.mem_we = 1'b1;
        tick("sw_rst_mem");
        reset = 1'b1;
        exp_base(3'd3);
        m = '1;
        e.mem_we = 1'b0;
        tick("sw_rst_reset");
        reset = 1'b0;
        cnt_model = 32'd0;
        run_nop("post_rst_nop");

        // Counter wrap.
        preload_cnt();
        run_nop("wrap_nop");
        do_if(6'h00, 6'h00, "wrap_after");

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have clk input, 1 bit: the single rising-edge clock.
REQ-002 SHALL have reset input, 1 bit: synchronous, active-high.
REQ-003 SHALL have op input, 6 bits: instruction opcode field from IR.
REQ-004 SHALL have func input, 6 bits: R-type function field from IR.
REQ-005 SHALL have zero input, 1 bit: ALU equality flag.
REQ-006 SHALL have mem_ready input, 1 bit: data memory completed access this cycle.
REQ-007 SHALL have state output, 3 bits: current FSM state.
REQ-008 SHALL have pc_we and ir_we outputs, 1 bit each: PC write and IR write strobes.
REQ-009 SHALL have npc_sel output, 2 bits: 00 PC+4, 01 branch, 10 jump imm26, 11 register.
REQ-010 SHALL have reg_we output, 1 bit, and reg_dst output, 2 bits: 00 rt, 01 rd, 10 $31.
REQ-011 SHALL have wd_sel output, 2 bits: 00 ALU, 01 memory, 10 PC+4.
REQ-012 SHALL have alu_src (0 reg, 1 imm) and ext_op (0 zero, 1 sign) outputs, 1 bit each.
REQ-013 SHALL have alu_op output, 3 bits: 000 add, 001 sub, 010 or, 011 lui.
REQ-014 SHALL have mem_re and mem_we outputs, 1 bit each: memory read and write requests.
REQ-015 SHALL have illegal output, 1 bit, and instr_cnt output, 32 bits: retired-instruction count.

Function
REQ-016 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 unreachable and SHALL go to IF.
REQ-017 IF SHALL assert ir_we=1, pc_we=1, npc_sel=00, then go to ID.
REQ-018 ID SHALL decode op/func into an internal class register that holds stable until the next ID.
REQ-019 Supported classes: addu (op 0, func 0x21), subu (op 0, func 0x23), ori (0x0D), lui (0x0F), lw (0x23), sw (0x2B), beq (0x04), jal (0x03), jr (op 0, func 0x08), nop (op 0, func 0).
REQ-020 Transitions from ID: nop -> IF; jal -> WB; illegal -> IF; all others -> EX.
REQ-021 EX: addu/subu/ori/lui -> WB; lw/sw -> MEM; beq/jr -> IF.
REQ-022 MEM: while mem_ready=0 SHALL remain in MEM holding mem_re (lw) or mem_we (sw) at 1.
REQ-023 MEM with mem_ready=1: lw -> WB; sw -> IF.
REQ-024 WB SHALL assert reg_we=1 for one cycle, then go to IF.
REQ-025 beq in EX SHALL assert alu_op=001 with alu_src=0, and pc_we=1 with npc_sel=01 only when zero=1.
REQ-026 jr in EX SHALL assert pc_we=1, npc_sel=11.
REQ-027 jal in WB SHALL assert pc_we=1, npc_sel=10, reg_we=1, reg_dst=10, wd_sel=10.
REQ-028 addu/subu SHALL use reg_dst=01, alu_src=0; ori SHALL use alu_src=1, ext_op=0, alu_op=010, reg_dst=00.
REQ-029 lui SHALL use alu_op=011, alu_src=1, reg_dst=00; lw/sw SHALL use alu_op=000, alu_src=1, ext_op=1; lw WB wd_sel=01.
REQ-030 Cycle counts SHALL be: nop 2; beq, jr, jal 3; addu, subu, ori, lui 4; sw 4+w; lw 5+w (w = MEM wait cycles).
REQ-031 Unlisted opcodes/funcs SHALL pulse illegal=1 for the ID cycle only and assert no reg_we, mem_we or extra pc_we.
REQ-032 instr_cnt SHALL increment by 1 on each transition into IF from a legal instruction (nop included), wrapping 0xFFFFFFFF -> 0.
REQ-033 All strobes (pc_we, ir_we, reg_we, mem_re, mem_we, illegal) SHALL be 0 in any state not listed as asserting them.

Reset
REQ-034 reset=1 at a clock edge SHALL set state=IF, class=nop, instr_cnt=0, regardless of current state, including mid-MEM wait.
REQ-035 While reset=1 all strobe outputs SHALL be forced to 0 and npc_sel, reg_dst, wd_sel, alu_op, alu_src, ext_op SHALL read 0.
REQ-036 First cycle after reset deasserts SHALL be IF with ir_we=1, pc_we=1.

Verification
REQ-037 addu (op 0, func 0x21) -> states 0,1,2,4,0; reg_we=1 only in WB with reg_dst=01; instr_cnt 0->1.
REQ-038 lw with mem_ready low 3 cycles -> MEM held 4 cycles with mem_re=1, then WB wd_sel=01; total 8 cycles.
REQ-039 beq with zero=0 then zero=1 -> pc_we in EX only in second case, npc_sel=01; each 3 cycles.
REQ-040 jal -> 0,1,4,0; WB: reg_dst=10, wd_sel=10, pc_we=1, npc_sel=10.
REQ-041 op=0x3F -> illegal=1 in ID, back to IF, instr_cnt unchanged, no reg_we/mem_we.
REQ-042 reset asserted during sw MEM wait with instr_cnt preloaded to 0xFFFFFFFF via 2^32 retirements (or forced) -> state=0, instr_cnt=0, mem_we=0 same cycle; wrap check: one more nop from 0xFFFFFFFF yields 0.
